spi_reg_bank: RTL



---
 rtl/spi_reg_pkg.sv | 38 +++
 rtl/spi_byte_rx.sv | 46 ++++
 rtl/spi_reg_bank.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank: command byte field positions,
// data/address widths, FSM state encoding and the burst address step helper.
// Optional macro SPI_REG_BANK_READ_EN (used by spi_reg_bank) enables readback.
package spi_reg_pkg;

    localparam int BYTE_W       = 8;
    localparam int ADDR_W       = 6;

    // Command byte layout: [7] R/W (1 = read), [6] auto-increment, [5:0] start address.
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_AI_BIT   = 6;
    localparam int CMD_ADDR_MSB = 5;

    // ST_IGN swallows read frames when the read path is not built.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_IGN
    } state_t;

    // Address step after each data byte. Addresses at or beyond the last
    // register either wrap to 0 or hold where they are.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic              ai,
        input logic              wrap,
        input logic [ADDR_W-1:0] last
    );
        if (!ai)
            return addr;
        if (addr >= last)
            return wrap ? '0 : addr;
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: deserialises MOSI (MSB first) while SSEL is low.
// Ports:
//   SCLK       - SPI clock, sole clock
//   rst_n      - synchronous active-low reset
//   SSEL       - active-low select; high clears any partial byte
//   MOSI       - serial data in
//   byte_valid - one-cycle pulse in the cycle after the 8th bit was sampled
//   byte_data  - completed byte, stable while byte_valid=1
module spi_byte_rx
    import spi_reg_pkg::*;
(
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data
);

    logic [2:0]        bit_cnt;
    // Only seven bits are held; the eighth is taken straight from MOSI so the
    // shifter can keep accepting the next byte without a gap.
    logic [BYTE_W-2:0] shift_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else if (SSEL) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt + 3'd1;
            shift_q    <= {shift_q[BYTE_W-3:0], MOSI};
            byte_valid <= (bit_cnt == 3'd7);
            if (bit_cnt == 3'd7)
                byte_data <= {shift_q, MOSI};
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave register bank: NUM_REGS byte registers written (and optionally
// read back) over SPI, with burst auto-increment and a write strobe.
// Optional macro: SPI_REG_BANK_READ_EN builds the MISO readback path; without
// it read frames are ignored and MISO is a presence flag (1 while selected).
// Ports:
//   SCLK      - SPI clock, sole clock
//   rst_n     - synchronous active-low reset
//   SSEL      - active-low slave select
//   MOSI      - serial data in, MSB first
//   MISO      - serial data out, registered; forced 0 while SSEL=1
//   regs_flat - all registers packed, reg i at [8*i+7:8*i]
//   wr_strobe - one-cycle pulse when a register is written
//   wr_addr   - address of the last write, valid while wr_strobe=1
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                    NUM_REGS        = 8,
    parameter logic [8*NUM_REGS-1:0] RESET_VALUES    = {NUM_REGS{8'h00}},
    parameter bit                    WRAP_EN_DEFAULT = 1'b1
) (
    input  logic                  SCLK,
    input  logic                  rst_n,
    input  logic                  SSEL,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;

    state_t            state_q, state_d;
    logic              ssel_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ai_q;
    logic [BYTE_W-1:0] regs_q [NUM_REGS];
    logic              cmd_valid;
    logic              data_valid;
    logic              wr_en;
    logic              miso_q;

    spi_byte_rx u_rx (
        .SCLK       (SCLK),
        .rst_n      (rst_n),
        .SSEL       (SSEL),
        .MOSI       (MOSI),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    assign cmd_valid  = byte_valid && (state_q == ST_CMD);
    assign data_valid = byte_valid && (state_q == ST_WR || state_q == ST_RD);
    // A byte completed on the edge before SSEL rose is still committed.
    assign wr_en      = byte_valid && (state_q == ST_WR) && (addr_q <= LAST_ADDR);

    // ssel_q is reset low so a reset in mid-frame waits for a fresh SSEL fall
    // instead of decoding the rest of the aborted frame as a new command.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ssel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ssel_q  <= SSEL;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (SSEL) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (ssel_q) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_valid) begin
                        if (!byte_data[CMD_RW_BIT])
                            state_d = ST_WR;
                        else
`ifdef SPI_REG_BANK_READ_EN
                            state_d = ST_RD;
`else
                            state_d = ST_IGN;
`endif
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: the bank is made of flops, not RAM, so each register is reset
    // explicitly to its image value.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            addr_q    <= '0;
            ai_q      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RESET_VALUES[8*i +: 8];
        end else begin
            wr_strobe <= 1'b0;
            if (cmd_valid) begin
                addr_q <= byte_data[CMD_ADDR_MSB:0];
                ai_q   <= byte_data[CMD_AI_BIT];
            end else if (data_valid) begin
                addr_q <= next_addr(addr_q, ai_q, WRAP_EN_DEFAULT, LAST_ADDR);
            end
            if (wr_en) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr_q;
                for (int i = 0; i < NUM_REGS; i++)
                    if (addr_q == ADDR_W'(i))
                        regs_q[i] <= byte_data;
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++)
            regs_flat[8*i +: 8] = regs_q[i];
    end

`ifdef SPI_REG_BANK_READ_EN
    logic [ADDR_W-1:0] rd_addr;
    logic [BYTE_W-1:0] rd_byte;
    logic [BYTE_W-1:0] tx_q;
    logic              tx_load;

    // The command byte supplies the first address; later boundaries use the
    // stepped address so the reload matches what the write path would use.
    assign rd_addr = cmd_valid ? byte_data[CMD_ADDR_MSB:0]
                               : next_addr(addr_q, ai_q, WRAP_EN_DEFAULT, LAST_ADDR);
    assign tx_load = (cmd_valid && byte_data[CMD_RW_BIT]) ||
                     (byte_valid && state_q == ST_RD);

    // Out-of-range addresses match no register and read as 0x00.
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == ADDR_W'(i))
                rd_byte = regs_q[i];
    end

    // miso_q carries the bit on the wire; tx_q holds the bits still to go,
    // left-aligned, zero-filled so idle states drive 0.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else if (SSEL) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else if (tx_load) begin
            tx_q   <= {rd_byte[BYTE_W-2:0], 1'b0};
            miso_q <= rd_byte[BYTE_W-1];
        end else begin
            tx_q   <= {tx_q[BYTE_W-2:0], 1'b0};
            miso_q <= tx_q[BYTE_W-1];
        end
    end
`else
    // Presence indicator: high while selected.
    always_ff @(posedge SCLK) begin
        if (!rst_n)
            miso_q <= 1'b0;
        else
            miso_q <= ~SSEL;
    end
`endif

    // Gating with SSEL keeps the line low the moment the master deselects.
    assign MISO = miso_q & ~SSEL;

endmodule
